// File: rtl/lander_dp_memory_if.sv
// rtl/lander_dp_memory_if.sv - one Avalon-MM style port of the dual-port memory
interface lander_dp_memory_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 17
);
  logic                  chipselect;
  logic                  read;
  logic                  write;
  logic                  clken;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W/8-1:0]   byteenable;
  logic [DATA_W-1:0]     writedata;
  logic [DATA_W-1:0]     readdata;
  logic                  readdatavalid;

  modport master (
    output chipselect, read, write, clken, address, byteenable, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  chipselect, read, write, clken, address, byteenable, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/lander_dp_memory.sv
// rtl/lander_dp_memory.sv - true dual-port byte-lane memory with old-data reads
// and per-port clock-enabled read pipelines; port 1 wins same-address write collisions.
module lander_dp_memory #(
  parameter int    DATA_W       = 32,
  parameter int    ADDR_W       = 17,
  parameter int    DEPTH        = 77500,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "memory.hex"
) (
  input  logic                clk,
  input  logic                reset,
  lander_dp_memory_if.slave   s1,
  lander_dp_memory_if.slave   s2,
  output logic [15:0]         collision_count,
  output logic                oor_flag
);
  localparam int              NB      = DATA_W / 8;
  localparam int              L       = READ_LATENCY;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  // Image loading from INIT_FILE is done by the device configuration flow.
  if (INIT_FILE != "") begin : g_init_image
  end

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [1:0]        wr_acc;
  logic [1:0]        rd_acc;
  logic [1:0]        in_rng;
  logic [1:0]        ce;
  logic [ADDR_W-1:0] addr    [2];
  logic [NB-1:0]     be      [2];
  logic [DATA_W-1:0] wd      [2];
  logic [DATA_W-1:0] rd_word [2];

  logic [L-1:0]      vld_q [2];
  logic [DATA_W-1:0] dat_q [2][L];
  logic [15:0]       coll_cnt_q, coll_cnt_d;
  logic              oor_q, oor_d;
  logic              coll;

  assign ce      = {s2.clken, s1.clken};
  assign addr[0] = s1.address;
  assign addr[1] = s2.address;
  assign be[0]   = s1.byteenable;
  assign be[1]   = s2.byteenable;
  assign wd[0]   = s1.writedata;
  assign wd[1]   = s2.writedata;

  assign wr_acc[0] = s1.chipselect & s1.write & s1.clken & ~reset;
  assign wr_acc[1] = s2.chipselect & s2.write & s2.clken & ~reset;
  assign rd_acc[0] = s1.chipselect & s1.read & ~s1.write & s1.clken & ~reset;
  assign rd_acc[1] = s2.chipselect & s2.read & ~s2.write & s2.clken & ~reset;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      in_rng[p]  = ({1'b0, addr[p]} < DEPTH_L);
      rd_word[p] = in_rng[p] ? mem_q[addr[p]] : '0;
    end
  end

  // Port 2 is applied first so port 1's bytes land last and win.
  always_ff @(posedge clk) begin
    for (int p = 1; p >= 0; p--) begin
      if (wr_acc[p] && in_rng[p]) begin
        for (int b = 0; b < NB; b++) begin
          if (be[p][b]) mem_q[addr[p]][b*8 +: 8] <= wd[p][b*8 +: 8];
        end
      end
    end
  end

  // Data stages only load on a valid, so the last stage holds the last returned word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        vld_q[p] <= '0;
        for (int s = 0; s < L; s++) dat_q[p][s] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (ce[p]) begin
          vld_q[p][0] <= rd_acc[p];
          if (rd_acc[p]) dat_q[p][0] <= rd_word[p];
          for (int s = L - 1; s > 0; s--) begin
            vld_q[p][s] <= vld_q[p][s-1];
            if (vld_q[p][s-1]) dat_q[p][s] <= dat_q[p][s-1];
          end
        end
      end
    end
  end

  always_comb begin
    coll = wr_acc[0] & wr_acc[1] & in_rng[0] & in_rng[1] & (addr[0] == addr[1]);
    coll_cnt_d = coll_cnt_q;
    if (coll && (coll_cnt_q != 16'hFFFF)) coll_cnt_d = coll_cnt_q + 16'd1;
    oor_d = oor_q | (|((wr_acc | rd_acc) & ~in_rng));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coll_cnt_q <= '0;
      oor_q      <= 1'b0;
    end else begin
      coll_cnt_q <= coll_cnt_d;
      oor_q      <= oor_d;
    end
  end

  assign s1.readdata      = dat_q[0][L-1];
  assign s1.readdatavalid = vld_q[0][L-1];
  assign s2.readdata      = dat_q[1][L-1];
  assign s2.readdatavalid = vld_q[1][L-1];
  assign collision_count  = coll_cnt_q;
  assign oor_flag         = oor_q;
endmodule

// File: tb/tb_lander_dp_memory.sv
// tb/tb_lander_dp_memory.sv - directed-vector bench for lander_dp_memory
module tb_lander_dp_memory;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] coll_a, coll_b;
  logic        oor_a, oor_b;
  int          n_vec = 0;
  int          n_miss = 0;

  always #5 clk = ~clk;

  lander_dp_memory_if #(.DATA_W(32), .ADDR_W(17)) a1 ();
  lander_dp_memory_if #(.DATA_W(32), .ADDR_W(17)) a2 ();
  lander_dp_memory_if #(.DATA_W(32), .ADDR_W(17)) b1 ();
  lander_dp_memory_if #(.DATA_W(32), .ADDR_W(17)) b2 ();

  lander_dp_memory #(.READ_LATENCY(1), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset), .s1(a1), .s2(a2),
    .collision_count(coll_a), .oor_flag(oor_a)
  );

  lander_dp_memory #(.READ_LATENCY(2), .INIT_FILE("")) dut2 (
    .clk(clk), .reset(reset), .s1(b1), .s2(b2),
    .collision_count(coll_b), .oor_flag(oor_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a1(input logic [16:0] a, input logic [31:0] d, input logic [3:0] be);
    a1.chipselect = 1'b1; a1.write = 1'b1; a1.address = a; a1.writedata = d; a1.byteenable = be;
    cyc();
    a1.chipselect = 1'b0; a1.write = 1'b0;
  endtask

  task automatic rd_a1(input logic [16:0] a, input logic [31:0] exp, input string tag);
    a1.chipselect = 1'b1; a1.read = 1'b1; a1.address = a;
    cyc();
    a1.chipselect = 1'b0; a1.read = 1'b0;
    chk({tag, "_valid"}, 32'(a1.readdatavalid), 32'd1);
    chk(tag, a1.readdata, exp);
  endtask

  task automatic wr_b1(input logic [16:0] a, input logic [31:0] d);
    b1.chipselect = 1'b1; b1.write = 1'b1; b1.address = a; b1.writedata = d; b1.byteenable = 4'hF;
    cyc();
    b1.chipselect = 1'b0; b1.write = 1'b0;
  endtask

  logic [31:0] stall_dat [4];
  int          stall_cyc [4];
  logic        stall_ce  [10];
  int          n_seen;
  int          n_valid;

  initial begin
    a1.chipselect = 0; a1.read = 0; a1.write = 0; a1.clken = 1; a1.address = '0; a1.byteenable = '0; a1.writedata = '0;
    a2.chipselect = 0; a2.read = 0; a2.write = 0; a2.clken = 1; a2.address = '0; a2.byteenable = '0; a2.writedata = '0;
    b1.chipselect = 0; b1.read = 0; b1.write = 0; b1.clken = 1; b1.address = '0; b1.byteenable = '0; b1.writedata = '0;
    b2.chipselect = 0; b2.read = 0; b2.write = 0; b2.clken = 1; b2.address = '0; b2.byteenable = '0; b2.writedata = '0;

    repeat (3) cyc();
    chk("rst_valid1", 32'(a1.readdatavalid), 32'd0);
    chk("rst_rdata1", a1.readdata, 32'd0);
    chk("rst_valid2", 32'(a2.readdatavalid), 32'd0);
    chk("rst_coll", 32'(coll_a), 32'd0);
    chk("rst_oor", 32'(oor_a), 32'd0);
    reset = 1'b0;
    cyc();

    // byte-lane write
    wr_a1(17'd5, 32'h11223344, 4'hF);
    wr_a1(17'd5, 32'hDEADBEEF, 4'b0101);
    rd_a1(17'd5, 32'h11AD33EF, "bytelane");
    cyc();
    chk("hold_valid", 32'(a1.readdatavalid), 32'd0);
    chk("hold_rdata", a1.readdata, 32'h11AD33EF);

    // read-during-write across ports
    wr_a1(17'd9, 32'h01020304, 4'hF);
    a1.chipselect = 1; a1.write = 1; a1.address = 17'd9; a1.writedata = 32'hAAAA5555; a1.byteenable = 4'hF;
    a2.chipselect = 1; a2.read = 1; a2.address = 17'd9;
    cyc();
    a1.chipselect = 0; a1.write = 0;
    chk("rdw_old_valid", 32'(a2.readdatavalid), 32'd1);
    chk("rdw_old", a2.readdata, 32'h01020304);
    cyc();
    a2.chipselect = 0; a2.read = 0;
    chk("rdw_new", a2.readdata, 32'hAAAA5555);

    // write-write collisions
    a1.chipselect = 1; a1.write = 1; a1.address = 17'd3; a1.writedata = 32'h000000FF; a1.byteenable = 4'hF;
    a2.chipselect = 1; a2.write = 1; a2.address = 17'd3; a2.writedata = 32'hFFFFFF00; a2.byteenable = 4'hF;
    cyc();
    chk("coll_cnt1", 32'(coll_a), 32'd1);
    a1.writedata = 32'h000000AA; a1.byteenable = 4'b0001;
    a2.writedata = 32'hBBBBBB00; a2.byteenable = 4'b1110;
    cyc();
    chk("coll_cnt2", 32'(coll_a), 32'd2);
    a1.chipselect = 0; a1.write = 0;
    a2.address = 17'd4;
    cyc();
    a2.chipselect = 0; a2.write = 0;
    rd_a1(17'd3, 32'hBBBBBBAA, "coll_disjoint");
    a1.chipselect = 1; a1.write = 1; a1.address = 17'd4; a1.writedata = 32'h1; a1.byteenable = 4'hF;
    a2.chipselect = 1; a2.write = 1; a2.address = 17'd3; a2.writedata = 32'h2; a2.byteenable = 4'hF;
    cyc();
    chk("coll_diff_addr", 32'(coll_a), 32'd2);
    a1.address = 17'd3; a1.writedata = 32'h000000FF;
    a2.writedata = 32'hFFFFFF00;
    cyc();
    a1.chipselect = 0; a1.write = 0;
    a2.chipselect = 0; a2.write = 0;
    rd_a1(17'd3, 32'h000000FF, "coll_p1_wins");
    a1.chipselect = 1; a1.write = 1;
    a2.chipselect = 1; a2.write = 1;
    repeat (65536) cyc();
    a1.chipselect = 0; a1.write = 0;
    a2.chipselect = 0; a2.write = 0;
    chk("coll_sat", 32'(coll_a), 32'h0000FFFF);

    // out of range
    wr_a1(17'd0, 32'h5A5A5A5A, 4'hF);
    chk("oor_clear", 32'(oor_a), 32'd0);
    wr_a1(17'd77500, 32'hFFFFFFFF, 4'hF);
    chk("oor_set", 32'(oor_a), 32'd1);
    rd_a1(17'd77500, 32'd0, "oor_read");
    rd_a1(17'd0, 32'h5A5A5A5A, "oor_word0");

    // stall/streaming on the two-cycle pipeline
    for (int i = 0; i < 4; i++) wr_b1(17'(20 + i), 32'hA000_0020 + 32'(i));
    stall_ce  = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    stall_cyc = '{1, 5, 6, 7};
    stall_dat = '{32'hA000_0020, 32'hA000_0021, 32'hA000_0022, 32'hA000_0023};
    n_seen = 0;
    for (int k = 0; k < 10; k++) begin
      b1.clken = stall_ce[k];
      b1.chipselect = (k == 0 || k == 1 || k == 5 || k == 6);
      b1.read = b1.chipselect;
      b1.address = (k < 2) ? 17'(20 + k) : 17'(17 + k);
      cyc();
      if (stall_ce[k] && b1.readdatavalid) begin
        if (n_seen < 4) begin
          chk("stall_cyc", 32'(k), 32'(stall_cyc[n_seen]));
          chk("stall_dat", b1.readdata, stall_dat[n_seen]);
        end
        n_seen++;
      end
    end
    b1.chipselect = 0; b1.read = 0; b1.clken = 1;
    chk("stall_count", 32'(n_seen), 32'd4);

    // reset one cycle after a read accept
    wr_b1(17'd7, 32'hCAFEF00D);
    b1.chipselect = 1; b1.read = 1; b1.address = 17'd7;
    cyc();
    reset = 1'b1;
    b1.read = 0; b1.write = 1; b1.writedata = 32'h12345678; b1.byteenable = 4'hF;
    #1;
    chk("rstmid_valid", 32'(b1.readdatavalid), 32'd0);
    chk("rstmid_rdata", b1.readdata, 32'd0);
    chk("rstmid_coll", 32'(coll_a), 32'd0);
    chk("rstmid_oor", 32'(oor_a), 32'd0);
    cyc();
    cyc();
    b1.chipselect = 0; b1.write = 0;
    reset = 1'b0;
    n_valid = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (b1.readdatavalid) n_valid++;
    end
    chk("rstmid_no_valid", 32'(n_valid), 32'd0);
    b1.chipselect = 1; b1.read = 1; b1.address = 17'd7;
    cyc();
    b1.chipselect = 0; b1.read = 0;
    cyc();
    chk("rstmid_mem_valid", 32'(b1.readdatavalid), 32'd1);
    chk("rstmid_mem", b1.readdata, 32'hCAFEF00D);
    rd_a1(17'd0, 32'h5A5A5A5A, "rst_keeps_mem");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/lander_dp_memory.md
LANDER_DP_MEMORY -- requirements
Module: lander_dp_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits; legal values are multiples of 8.
REQ-002 SHALL have parameter ADDR_W, default 17, width of the word address.
REQ-003 SHALL have parameter DEPTH, default 77500, number of words; legal range is 1 to 2^ADDR_W.
REQ-004 SHALL have parameter READ_LATENCY, default 1, cycles from read accept to readdatavalid; legal values are 1 and 2.
REQ-005 SHALL have parameter INIT_FILE, default "memory.hex", the power-up contents image.
REQ-006 SHALL use one clock and an asynchronous, active-high reset: clk  in  1  sole clock, all logic on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 s1_chipselect, s1_read, s1_write  in  1 each  port-1 Avalon-MM controls.
REQ-009 s1_address  in  ADDR_W  port-1 word address.
REQ-010 s1_byteenable  in  DATA_W/8  port-1 byte lanes.
REQ-011 s1_writedata  in  DATA_W  port-1 write data.
REQ-012 s1_clken  in  1  port-1 clock enable.
REQ-013 s1_readdata  out  DATA_W  port-1 read data.
REQ-014 s1_readdatavalid  out  1  port-1 read data qualifier.
REQ-015 s2_* SHALL be identical to s1_* in direction, width and meaning, for port 2.
REQ-016 collision_count  out  16  saturating count of same-address write-write collisions.
REQ-017 oor_flag  out  1  sticky flag, set on any out-of-range access.

Function
REQ-018 Port n SHALL accept a write when sn_chipselect & sn_write & sn_clken is 1.
REQ-019 Port n SHALL accept a read when sn_chipselect & sn_read & ~sn_write & sn_clken is 1; read and write asserted together SHALL be treated as a write.
REQ-020 A write SHALL update only the bytes whose byteenable bit is 1; data is visible to reads accepted on the following cycle.
REQ-021 A read SHALL return memory contents from before any write accepted in the same cycle, on both the same port and the other port (old-data semantics).
REQ-022 The read pipeline per port SHALL hold a READ_LATENCY-deep valid/data shift register.
REQ-023 sn_readdatavalid SHALL assert exactly READ_LATENCY cycles after an accepted read, for one cycle per read; back-to-back reads SHALL give back-to-back valids (throughput 1/cycle).
REQ-024 While sn_clken is 0, port n's pipeline SHALL freeze: no shift, outputs held; latency is counted in enabled cycles only.
REQ-025 sn_readdata SHALL hold its last valid value when sn_readdatavalid is 0.
REQ-026 An address >= DEPTH SHALL be out of range: writes are discarded, reads return all zeros with normal readdatavalid timing, and oor_flag is set.
REQ-027 Simultaneous in-range writes from both ports to the same address SHALL apply port 1's enabled bytes over port 2's, i.e. port 1 wins per byte.
REQ-028 Each such collision SHALL increment collision_count by 1, saturating at 16'hFFFF.
REQ-029 Simultaneous writes with disjoint byteenables SHALL both take effect and SHALL still count as a collision.

Reset
REQ-030 On reset assertion, asynchronously: sn_readdatavalid=0, sn_readdata=0, pipeline valids=0, collision_count=0, oor_flag=0.
REQ-031 Reset SHALL NOT alter memory contents; contents come from INIT_FILE at configuration only.
REQ-032 Reads in flight when reset asserts SHALL be dropped, with no readdatavalid after reset is released.
REQ-033 Accesses presented while reset is high SHALL be ignored.

Verification
REQ-034 Byte-lane write: s1 writes 0xDEADBEEF to addr 5 with be=4'b0101 over 0x11223344; s1 reads addr 5 -> readdata 0x11AD33EF, valid at accept+READ_LATENCY.
REQ-035 Mixed read-during-write: s1 writes 0xAAAA5555 to addr 9 while s2 reads addr 9 in the same cycle -> s2 gets the old value; an s2 re-read the next cycle gets 0xAAAA5555.
REQ-036 Collision: s1 writes 0x000000FF and s2 writes 0xFFFFFF00 to addr 3, both be=4'hF -> addr 3 = 0x000000FF and collision_count=1; repeat 65536 times -> count stays 0xFFFF.
REQ-037 Out of range: DEPTH=77500, write to 77500 then read 77500 -> readdata 0, oor_flag=1, word 0 unchanged.
REQ-038 Stall/streaming: READ_LATENCY=2, 4 back-to-back reads with s1_clken low for 3 cycles mid-stream -> 4 valids in order, delayed by exactly 3 cycles.
REQ-039 Reset mid-read: assert reset one cycle after a read accept -> no readdatavalid ever for that read; all outputs 0 and memory contents preserved.
